// File: rtl/logic_sweep_ctrl.sv
// Truth-table sweep controller: steps {C,B,A} through 0..7, lets the gate
// datapath settle, captures x/y per vector and grades them against golden tables.
module logic_sweep_ctrl #(
    parameter logic [7:0] EXP_X = 8'h8F,
    parameter logic [7:0] EXP_Y = 8'h0F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] dwell,
    output logic [2:0] abc_out,
    input  logic       x_in,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] tt_x,
    output logic [7:0] tt_y,
    output logic [3:0] mismatch_cnt,
    output logic [2:0] first_fail
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [2:0] r_vec;
    logic [3:0] r_cnt;
    logic [3:0] r_dwell;

    logic       w_mis;
    logic [3:0] w_mis_next;

    assign w_mis      = (x_in != EXP_X[r_vec]) || (y_in != EXP_Y[r_vec]);
    assign w_mis_next = mismatch_cnt + 4'(w_mis);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_vec        <= 3'd0;
            r_cnt        <= 4'd0;
            r_dwell      <= 4'd0;
            abc_out      <= 3'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            tt_x         <= 8'd0;
            tt_y         <= 8'd0;
            mismatch_cnt <= 4'd0;
            first_fail   <= 3'd0;
        end else if (ena) begin
            if (abort) begin
                // Results of the cancelled sweep are left visible; only status drops.
                r_state <= S_IDLE;
                r_vec   <= 3'd0;
                r_cnt   <= 4'd0;
                abc_out <= 3'd0;
                busy    <= 1'b0;
                done    <= 1'b0;
                pass    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_state      <= S_SETTLE;
                            r_vec        <= 3'd0;
                            r_cnt        <= dwell;
                            r_dwell      <= dwell;
                            abc_out      <= 3'd0;
                            busy         <= 1'b1;
                            done         <= 1'b0;
                            pass         <= 1'b0;
                            tt_x         <= 8'd0;
                            tt_y         <= 8'd0;
                            mismatch_cnt <= 4'd0;
                            first_fail   <= 3'd0;
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt == 4'd0) begin
                            r_state <= S_SAMPLE;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    S_SAMPLE: begin
                        tt_x[r_vec] <= x_in;
                        tt_y[r_vec] <= y_in;
                        if (w_mis) begin
                            mismatch_cnt <= w_mis_next;
                            if (mismatch_cnt == 4'd0) begin
                                first_fail <= r_vec;
                            end
                        end
                        if (r_vec == 3'd7) begin
                            r_state <= S_DONE;
                            abc_out <= 3'd0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (w_mis_next == 4'd0);
                        end else begin
                            r_state <= S_SETTLE;
                            r_vec   <= r_vec + 3'd1;
                            abc_out <= r_vec + 3'd1;
                            r_cnt   <= r_dwell;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl: gate datapath with fault injection, a timeline
// model of the sweep, per-cycle output comparison and directed scenarios.
module tb_logic_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] dwell = 4'd0;
    logic [2:0] abc_out;
    logic       x_in;
    logic       y_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] tt_x;
    logic [7:0] tt_y;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_fail;

    logic x_s0 = 1'b0;
    logic y_s1 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [7:0] GX = 8'h8F;
    localparam logic [7:0] GY = 8'h0F;

    always #5 clk = ~clk;

    assign x_in = x_s0 ? 1'b0 : ((abc_out[0] & abc_out[1]) | ~abc_out[2]);
    assign y_in = y_s1 ? 1'b1 : ~abc_out[2];

    logic_sweep_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start        (start),
        .abort        (abort),
        .dwell        (dwell),
        .abc_out      (abc_out),
        .x_in         (x_in),
        .y_in         (y_in),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .tt_x         (tt_x),
        .tt_y         (tt_y),
        .mismatch_cnt (mismatch_cnt),
        .first_fail   (first_fail)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 sweeping, 2 done; m_t counts edges since the start edge.
    int         m_mode = 0;
    int         m_t = 0;
    logic [3:0] m_d = 4'd0;
    logic [7:0] m_x = 8'd0;
    logic [7:0] m_y = 8'd0;
    logic [7:0] m_cap = 8'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_t = 0; m_d = 4'd0;
            m_x = 8'd0; m_y = 8'd0; m_cap = 8'd0;
        end else if (ena) begin
            if (abort) begin
                m_mode = 0;
                m_t = 0;
            end else if (m_mode != 1 && start) begin
                m_mode = 1; m_t = 0; m_d = dwell;
                m_x = 8'd0; m_y = 8'd0; m_cap = 8'd0;
            end else if (m_mode == 1) begin
                int len;
                int v;
                len = int'(m_d) + 2;
                if (m_t % len == len - 1) begin
                    v = m_t / len;
                    m_x[v] = x_in;
                    m_y[v] = y_in;
                    m_cap[v] = 1'b1;
                end
                m_t++;
                if (m_t == 8 * len) m_mode = 2;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] bad;
        int         cnt;
        int         ff;
        int         len;
        bad = ((m_x ^ GX) | (m_y ^ GY)) & m_cap;
        cnt = 0;
        ff = -1;
        for (int i = 0; i < 8; i++) begin
            if (bad[i]) begin
                cnt++;
                if (ff < 0) ff = i;
            end
        end
        if (ff < 0) ff = 0;
        len = int'(m_d) + 2;
        check("abc_out", 32'(abc_out),
              (m_mode == 1) ? 32'(m_t / len) : 32'd0);
        check("busy", 32'(busy), 32'(m_mode == 1));
        check("done", 32'(done), 32'(m_mode == 2));
        check("pass", 32'(pass), 32'(m_mode == 2 && cnt == 0));
        check("tt_x", 32'(tt_x), 32'(m_x));
        check("tt_y", 32'(tt_y), 32'(m_y));
        check("mismatch_cnt", 32'(mismatch_cnt), 32'(cnt));
        check("first_fail", 32'(first_fail), 32'(ff));
    end

    task automatic sweep(input logic [3:0] d, input int chg, input int spam,
                         input int frz_vec, input int frz_len,
                         output int edges);
        bit frozen;
        frozen = 1'b0;
        dwell = d;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (chg >= 0) dwell = 4'(chg);
        edges = 0;
        while (!done && edges < 400) begin
            if (frz_vec >= 0 && !frozen && busy && abc_out == 3'(frz_vec)) begin
                ena = 1'b0;
                start = 1'b1;
                abort = 1'b1;
                repeat (frz_len) begin
                    @(posedge clk);
                    edges++;
                end
                @(negedge clk);
                check("frozen_abc", 32'(abc_out), 32'(frz_vec));
                ena = 1'b1;
                start = 1'b0;
                abort = 1'b0;
                frozen = 1'b1;
            end
            if (spam != 0) start = (edges % 2 == 1);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        if (edges >= 400) check("sweep_timeout", 32'(edges), 32'd0);
    endtask

    task automatic wait_vec(input logic [2:0] v);
        int n;
        n = 0;
        while (abc_out != v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("wait_vec_timeout", 32'(abc_out), 32'(v));
    endtask

    initial begin
        int e;
        #3;
        check("rst_abc", 32'(abc_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tt_x", 32'(tt_x), 32'd0);
        check("rst_mis", 32'(mismatch_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep(4'd0, -1, 0, -1, 0, e);
        check("d0_edges", 32'(e), 32'd16);
        check("d0_tt_x", 32'(tt_x), 32'h8F);
        check("d0_tt_y", 32'(tt_y), 32'h0F);
        check("d0_mis", 32'(mismatch_cnt), 32'd0);
        check("d0_pass", 32'(pass), 32'd1);
        repeat (5) @(negedge clk);
        check("hold_done", 32'(done), 32'd1);

        sweep(4'd3, 0, 1, -1, 0, e);
        check("d3_edges", 32'(e), 32'd40);
        check("d3_pass", 32'(pass), 32'd1);

        x_s0 = 1'b1;
        sweep(4'd0, -1, 0, -1, 0, e);
        check("xs0_tt_x", 32'(tt_x), 32'h00);
        check("xs0_mis", 32'(mismatch_cnt), 32'd5);
        check("xs0_ff", 32'(first_fail), 32'd0);
        check("xs0_pass", 32'(pass), 32'd0);
        x_s0 = 1'b0;
        y_s1 = 1'b1;
        sweep(4'd1, -1, 0, -1, 0, e);
        check("ys1_tt_y", 32'(tt_y), 32'hFF);
        check("ys1_mis", 32'(mismatch_cnt), 32'd4);
        check("ys1_ff", 32'(first_fail), 32'd4);
        check("ys1_pass", 32'(pass), 32'd0);
        y_s1 = 1'b0;

        dwell = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_vec(3'd3);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_abc", 32'(abc_out), 32'd0);
        sweep(4'd0, -1, 0, -1, 0, e);
        check("post_abort_edges", 32'(e), 32'd16);
        check("post_abort_pass", 32'(pass), 32'd1);

        sweep(4'd0, -1, 0, 5, 10, e);
        check("freeze_edges", 32'(e), 32'd26);

        dwell = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_abc", 32'(abc_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_tt_x", 32'(tt_x), 32'd0);
        check("arst_tt_y", 32'(tt_y), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        sweep(4'd2, -1, 0, -1, 0, e);
        check("post_rst_edges", 32'(e), 32'd32);
        check("post_rst_tt_x", 32'(tt_x), 32'h8F);
        check("post_rst_pass", 32'(pass), 32'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
